// File: rtl/rv32_ifu_fetch_buf_if.sv
// Fetch-buffer bus: ICCM read port, execute redirect, and decode handshake.
// The master side is the fetch unit. The slave side is its environment (ICCM, execute, decode).
interface rv32_ifu_fetch_buf_if;
    logic        iccm_rd_en;
    logic [31:0] iccm_rd_addr;
    logic [31:0] iccm_rd_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;

    modport master (
        output iccm_rd_en, iccm_rd_addr, instr_valid, instr_data, instr_pc,
        input  iccm_rd_data, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  iccm_rd_en, iccm_rd_addr, instr_valid, instr_data, instr_pc,
        output iccm_rd_data, redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/rv32_ifu_fetch_buf.sv
// Sequential ICCM fetch feeding a credit-checked prefetch FIFO toward decode.
// A redirect flushes the FIFO and discards any outstanding read.
module rv32_ifu_fetch_buf #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    rv32_ifu_fetch_buf_if.master    bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             inflight, kill;
    logic [31:0]      fetch_pc, resp_pc;
    logic [31:0]      data_mem [DEPTH];
    logic [31:0]      pc_mem   [DEPTH];

    logic [CNT_W-1:0] credits_used;
    logic             can_issue, issue, push, pop;

    // The credit check ignores same-cycle pops, so a push always finds a free slot.
    assign credits_used = count + CNT_W'(inflight);
    assign can_issue    = credits_used < CNT_W'(DEPTH);
    // rst_n gates the request so the ICCM sees no read while reset is held.
    assign issue        = can_issue & ~bus.redirect_valid & rst_n;
    assign push         = inflight & ~kill & ~bus.redirect_valid;
    assign pop          = (count != '0) & bus.instr_ready;

    assign bus.iccm_rd_en   = issue;
    assign bus.iccm_rd_addr = {fetch_pc[31:2], 2'b00};
    assign bus.instr_valid  = (count != '0);
    assign bus.instr_data   = data_mem[rd_ptr];
    assign bus.instr_pc     = pc_mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= 1'b0;
            kill     <= 1'b0;
            fetch_pc <= RESET_PC;
            resp_pc  <= '0;
            // NOTE: the storage is reset because the head is read straight from it and must show 0 in reset.
            for (int i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (bus.redirect_valid) begin
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= 1'b0;
            kill     <= 1'b1;
            fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
        end else begin
            kill     <= 1'b0;
            inflight <= issue;
            if (issue) begin
                fetch_pc <= {fetch_pc[31:2], 2'b00} + 32'd4;
                resp_pc  <= {fetch_pc[31:2], 2'b00};
            end
            if (push) begin
                data_mem[wr_ptr] <= bus.iccm_rd_data;
                pc_mem[wr_ptr]   <= resp_pc;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_rv32_ifu_fetch_buf.sv
// Randomized bench for rv32_ifu_fetch_buf against a queue-based model of the fetch buffer.
// The ICCM is modelled as a fixed hash of the address, and directed redirect and reset scenarios run first.
module tb_rv32_ifu_fetch_buf;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    logic clk;
    logic rst_n;
    rv32_ifu_fetch_buf_if bus();

    rv32_ifu_fetch_buf #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model state: FIFO contents, next fetch address, and the outstanding request.
    entry_t      m_q[$];
    logic [31:0] m_fetch_pc;
    logic        m_pending;
    logic [31:0] m_pending_pc;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_fetch_pc = RESET_PC;
        m_pending  = 1'b0;
    endtask

    // Called at a negedge, it applies inputs, checks outputs, advances one clock, and returns at the next negedge.
    task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc);
        logic        exp_en, exp_valid, got_en;
        logic [31:0] got_addr;
        entry_t      e;
        bus.instr_ready    = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        #1;
        exp_en    = ((m_q.size() + (m_pending ? 1 : 0)) < DEPTH) && !rv;
        exp_valid = (m_q.size() != 0);
        check("rd_en", 32'(bus.iccm_rd_en), 32'(exp_en));
        if (exp_en) check("rd_addr", bus.iccm_rd_addr, {m_fetch_pc[31:2], 2'b00});
        check("valid", 32'(bus.instr_valid), 32'(exp_valid));
        if (exp_valid) begin
            check("head_pc", bus.instr_pc, m_q[0].pc);
            check("head_data", bus.instr_data, m_q[0].data);
        end
        got_en   = bus.iccm_rd_en;
        got_addr = bus.iccm_rd_addr;
        @(posedge clk);
        if (rv) begin
            m_q.delete();
            m_pending  = 1'b0;
            m_fetch_pc = {rpc[31:2], 2'b00};
        end else begin
            if (exp_valid && rdy) void'(m_q.pop_front());
            if (m_pending) begin
                e.pc   = m_pending_pc;
                e.data = mem_word(m_pending_pc);
                m_q.push_back(e);
            end
            m_pending = exp_en;
            if (exp_en) begin
                m_pending_pc = {m_fetch_pc[31:2], 2'b00};
                m_fetch_pc   = {m_fetch_pc[31:2], 2'b00} + 32'd4;
            end
        end
        #1;
        bus.iccm_rd_data = got_en ? mem_word(got_addr) : $urandom;
        cyc++;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
        check({tag, "_rd_en"}, 32'(bus.iccm_rd_en), 32'd0);
        check({tag, "_data"}, bus.instr_data, 32'd0);
        check({tag, "_pc"}, bus.instr_pc, 32'd0);
    endtask

    initial begin
        logic [31:0] rpc;
        rst_n              = 1'b0;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.iccm_rd_data   = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Startup streaming with decode always ready.
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, '0);

        // Backpressure: fill, hold, then drain.
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, '0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, '0);

        // Redirect while the FIFO holds 0x10/0x14 and 0x18 is in flight.
        cycle(1'b0, 1'b1, 32'h0000_0010);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 32'h0000_0200);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0);
        // Redirect and pop together with three entries queued.
        cycle(1'b1, 1'b1, 32'h0000_0300);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, '0);

        // Misaligned redirect near the top of the address space, then back-to-back redirects.
        cycle(1'b1, 1'b1, 32'hFFFF_FFFE);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, 32'h0000_1000);
        cycle(1'b1, 1'b1, 32'h0000_2002);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, '0);

        // Reset asserted mid-cycle with the FIFO full.
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        @(negedge clk);
        bus.iccm_rd_data = $urandom;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, '0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0:       rpc = 32'hFFFF_FFFE;
                1:       rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                default: rpc = $urandom;
            endcase
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0), rpc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rv32_ifu_fetch_buf.md
Name: rv32_ifu_fetch_buf

Overview:
Instruction fetch unit with a small prefetch buffer. It sits directly upstream of the core's decode stage and drives the ICCM read port. It sequentially fetches 32-bit words from ICCM and queues each instruction with its PC. It delivers them to decode over a valid/ready handshake and flushes on control-flow redirects.

Parameters:
DEPTH, 4, prefetch FIFO entries (power of 2, >=2)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  core clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
iccm_rd_en  output  1  ICCM read request this cycle
iccm_rd_addr  output  32  byte address of the request; always word-aligned, [1:0]=2'b00
iccm_rd_data  input  32  ICCM read data, valid exactly 1 cycle after iccm_rd_en
redirect_valid  input  1  branch/jump/trap redirect from execute
redirect_pc  input  32  new fetch address; bits [1:0] ignored
instr_valid  output  1  FIFO head holds a valid instruction
instr_ready  input  1  decode accepts the head this cycle
instr_data  output  32  instruction at FIFO head
instr_pc  output  32  byte PC of instr_data

Behaviour:
- Reset is asynchronous and active-low on rst_n. While reset is asserted: fetch_pc=RESET_PC, FIFO count=0, inflight=0, instr_valid=0, iccm_rd_en=0. instr_data and instr_pc read 0.
- Issue condition: can_issue = (count + inflight) < DEPTH. Same-cycle pops are not credited, so the check is conservative.
- iccm_rd_en = can_issue & ~redirect_valid (combinational). iccm_rd_addr = {fetch_pc[31:2],2'b00}.
- On issue: fetch_pc <= fetch_pc+4, wrapping mod 2^32 (32'hFFFF_FFFC -> 0). inflight <= 1, and the PC of the request is stored in a resp_pc register.
- Response: in the cycle after an issue with no intervening redirect, {iccm_rd_data, resp_pc} is pushed to the FIFO tail. Capacity is always available because of the credit check.
- Throughput: with instr_ready held high, one instruction per cycle after a 2-cycle startup (issue, then push; instr_valid high on the next edge).
- FIFO: instr_valid = (count != 0). Head fields are driven directly from the storage array. Pop when instr_valid & instr_ready.
- Push and pop in the same cycle leave count unchanged. Pointers wrap mod DEPTH.
- Head stability: while instr_valid=1 and instr_ready=0, instr_data and instr_pc hold stable.
- Redirect, when redirect_valid=1 in a cycle:
  - count <= 0; inflight <= 0.
  - Any response returning in the next cycle is discarded via a kill flag.
  - fetch_pc <= {redirect_pc[31:2],2'b00}.
  - No issue occurs in the redirect cycle; the first fetch at the new PC issues the following cycle.
- Redirect wins over everything else in the same cycle: a simultaneous pop is accepted by decode but the rest of the FIFO is dropped, and a simultaneous push is dropped.
- Back-to-back redirects: the last one wins, and only one fetch issues after the final redirect.
- Reset mid-operation: all state returns to reset values immediately. Any ICCM response arriving after reset release is ignored, because inflight was cleared.
- No internal state machine beyond counters and flags: count (log2(DEPTH)+1 bits), wr_ptr, rd_ptr, inflight, kill.

Test Plan:
- Startup: release rst_n with instr_ready=1.
  -> iccm_rd_addr sequence 0x0, 0x4, 0x8 on consecutive cycles.
  -> instr_valid rises 2 cycles after the first iccm_rd_en, with instr_pc=0x0 and the matching data, then 1 instr/cycle.
- Backpressure: hold instr_ready=0.
  -> exactly 4 reads issue (0x0..0xC), then iccm_rd_en=0; head holds pc 0x0.
  -> raise ready: pcs 0x0, 0x4, 0x8, 0xC, 0x10 emerge in order, none lost or duplicated.
- Redirect with inflight: FIFO holding pcs 0x10/0x14 and a read at 0x18 in flight, assert redirect_pc=0x200 for 1 cycle.
  -> instr_valid=0 the next cycle; the 0x18 response is dropped.
  -> next iccm_rd_addr=0x200; first delivered instr_pc=0x200.
- Redirect plus pop same cycle: FIFO count=3, instr_ready=1, redirect_valid=1.
  -> count=0 after the edge; only the head was consumed.
- Misaligned redirect and wrap: redirect_pc=0xFFFF_FFFE.
  -> fetch addresses 0xFFFF_FFFC then 0x0000_0000.
- Reset mid-stream: assert rst_n=0 asynchronously mid-cycle with the FIFO full.
  -> instr_valid and iccm_rd_en go 0 immediately.
  -> after release, first fetch is at RESET_PC.
